// File: rtl/axi_top.sv
// AXI4 write/read-back self-test: an INCR-burst master writes a known pattern into
// a word-addressed memory slave, reads it back and flags any data or response error.
module axi_top #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 16,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned NUM_BURSTS = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic req_finish,
  output logic req_error
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'd2;
  localparam logic [7:0] AXLEN       = 8'(BURST_LEN - 1);

  localparam logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(32'hA5A5_0000);
  localparam logic [BURST_W-1:0]    LAST_BURST = BURST_W'(NUM_BURSTS - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

  logic [ADDR_W-1:0]     awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast, wvalid, wready;
  logic [1:0]            bresp;
  logic                  bvalid, bready;
  logic [ADDR_W-1:0]     araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid, arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast, rvalid, rready;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [BURST_W-1:0] b,
                                                          input logic [BEAT_W-1:0] k);
    return PATTERN | DATA_WIDTH'(32'(b) * BURST_LEN + 32'(k));
  endfunction

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [BURST_W-1:0] b);
    return ADDR_W'(32'(b) * BURST_LEN * 32'd4);
  endfunction

  // ---------------------------------------------------------------- master
  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } m_state_e;

  m_state_e              m_state_q, m_state_d;
  logic [BURST_W-1:0]    m_burst_q, m_burst_d;
  logic [BEAT_W-1:0]     m_beat_q, m_beat_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  wlast_q, wlast_d, finish_q, finish_d, error_q, error_d;
  logic [ADDR_W-1:0]     maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_comb begin
    m_state_d = m_state_q;
    m_burst_d = m_burst_q;
    m_beat_d  = m_beat_q;
    error_d   = error_q;
    case (m_state_q)
      IDLE:    m_state_d = WR_ADDR;
      WR_ADDR: if (aw_hs) begin
        m_state_d = WR_DATA;
        m_beat_d  = '0;
      end
      WR_DATA: if (w_hs) begin
        if (wlast_q) begin
          m_state_d = WR_RESP;
          m_beat_d  = '0;
        end else begin
          m_beat_d = m_beat_q + BEAT_W'(1);
        end
      end
      WR_RESP: if (b_hs) begin
        if (bresp != RESP_OKAY) error_d = 1'b1;
        if (m_burst_q == LAST_BURST) begin
          m_state_d = RD_ADDR;
          m_burst_d = '0;
        end else begin
          m_state_d = WR_ADDR;
          m_burst_d = m_burst_q + BURST_W'(1);
        end
      end
      RD_ADDR: if (ar_hs) begin
        m_state_d = RD_DATA;
        m_beat_d  = '0;
      end
      RD_DATA: if (r_hs) begin
        // Each returned beat must equal the pattern that was written to that word
        if ((rdata != pattern_word(m_burst_q, m_beat_q)) || (rresp != RESP_OKAY)) error_d = 1'b1;
        if (rlast) begin
          m_beat_d = '0;
          if (m_burst_q == LAST_BURST) begin
            m_state_d = DONE;
          end else begin
            m_state_d = RD_ADDR;
            m_burst_d = m_burst_q + BURST_W'(1);
          end
        end else begin
          m_beat_d = m_beat_q + BEAT_W'(1);
        end
      end
      DONE:    m_state_d = DONE;
      default: m_state_d = IDLE;
    endcase

    // Channel controls are decoded from the next state so they leave a flop
    awvalid_d = (m_state_d == WR_ADDR);
    wvalid_d  = (m_state_d == WR_DATA);
    bready_d  = (m_state_d == WR_RESP);
    arvalid_d = (m_state_d == RD_ADDR);
    rready_d  = (m_state_d == RD_DATA);
    finish_d  = (m_state_d == DONE);
    maddr_d   = burst_addr(m_burst_d);
    wdata_d   = pattern_word(m_burst_d, m_beat_d);
    wlast_d   = (m_beat_d == LAST_BEAT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_state_q <= IDLE;
      m_burst_q <= '0;
      m_beat_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wlast_q   <= 1'b0;
      finish_q  <= 1'b0;
      error_q   <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      m_state_q <= m_state_d;
      m_burst_q <= m_burst_d;
      m_beat_q  <= m_beat_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wlast_q   <= wlast_d;
      finish_q  <= finish_d;
      error_q   <= error_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign awaddr     = maddr_q;
  assign awlen      = AXLEN;
  assign awsize     = SIZE_WORD;
  assign awburst    = BURST_INCR;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = '1;
  assign wlast      = wlast_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;
  assign araddr     = maddr_q;
  assign arlen      = AXLEN;
  assign arsize     = SIZE_WORD;
  assign arburst    = BURST_INCR;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign req_finish = finish_q;
  assign req_error  = error_q;

  // ----------------------------------------------------------------- slave
  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R
  } s_state_e;

  s_state_e                             s_state_q, s_state_d;
  logic [ADDR_W-3:0]                    s_word_q, s_word_d;
  logic [7:0]                           s_len_q, s_len_d, s_beat_q, s_beat_d;
  logic                                 s_ok_q, s_ok_d;
  logic [MEM_WORDS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic                                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                                 arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]                           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]                rdata_q, rdata_d;
  logic [IDX_W-1:0]                     w_idx;

  // Word index wraps modulo the memory depth
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-3:0] word,
                                                input logic [7:0] beat);
    return IDX_W'((32'(word) + 32'(beat)) % MEM_WORDS);
  endfunction

  assign w_idx = word_idx(s_word_q, s_beat_q);

  always_comb begin
    s_state_d = s_state_q;
    s_word_d  = s_word_q;
    s_len_d   = s_len_q;
    s_ok_d    = s_ok_q;
    s_beat_d  = s_beat_q;
    mem_d     = mem_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (s_state_q)
      S_IDLE: begin
        if (awvalid)      s_state_d = S_AW;
        else if (arvalid) s_state_d = S_AR;
      end
      S_AW: if (aw_hs) begin
        s_state_d = S_W;
        s_word_d  = awaddr[ADDR_W-1:2];
        s_len_d   = awlen;
        s_ok_d    = (awaddr[1:0] == 2'b00) && (awsize == SIZE_WORD) && (awburst == BURST_INCR);
        s_beat_d  = '0;
      end
      S_W: if (w_hs) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wstrb[i]) mem_d[w_idx][8*i +: 8] = wdata[8*i +: 8];
        end
        s_beat_d = s_beat_q + 8'd1;
        if (wlast) begin
          s_state_d = S_B;
          bresp_d   = (s_ok_q && (s_beat_q == s_len_q)) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      S_B: if (b_hs) s_state_d = S_IDLE;
      S_AR: if (ar_hs) begin
        s_state_d = S_R;
        s_word_d  = araddr[ADDR_W-1:2];
        s_len_d   = arlen;
        s_beat_d  = '0;
        rdata_d   = mem_q[word_idx(araddr[ADDR_W-1:2], 8'd0)];
        rresp_d   = ((araddr[1:0] == 2'b00) && (arsize == SIZE_WORD) && (arburst == BURST_INCR))
                    ? RESP_OKAY : RESP_SLVERR;
        rlast_d   = (arlen == 8'd0);
      end
      S_R: if (r_hs) begin
        if (rlast_q) begin
          s_state_d = S_IDLE;
        end else begin
          s_beat_d = s_beat_q + 8'd1;
          rdata_d  = mem_q[word_idx(s_word_q, s_beat_q + 8'd1)];
          rlast_d  = ((s_beat_q + 8'd1) == s_len_q);
        end
      end
      default: s_state_d = S_IDLE;
    endcase

    awready_d = (s_state_d == S_AW);
    wready_d  = (s_state_d == S_W);
    bvalid_d  = (s_state_d == S_B);
    arready_d = (s_state_d == S_AR);
    rvalid_d  = (s_state_d == S_R);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_state_q <= S_IDLE;
      s_word_q  <= '0;
      s_len_q   <= '0;
      s_ok_q    <= 1'b0;
      s_beat_q  <= '0;
      mem_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      s_state_q <= s_state_d;
      s_word_q  <= s_word_d;
      s_len_q   <= s_len_d;
      s_ok_q    <= s_ok_d;
      s_beat_q  <= s_beat_d;
      mem_q     <= mem_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_top.sv
// Scenario-table bench for axi_top: clean runs, random mid-sequence resets and
// corrupted memory words, checked against a pattern/memory model of the sequence.
module tb_axi_top;

  localparam int unsigned NB = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned MW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_finish, req_error;

  axi_top #(
    .DATA_WIDTH(32), .MEM_WORDS(MW), .BURST_LEN(BL), .NUM_BURSTS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_finish(req_finish), .req_error(req_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] aw_addr_q[$], ar_addr_q[$], w_data_q[$], r_data_q[$];
  logic [7:0]  aw_len_q[$], ar_len_q[$];
  logic        w_last_q[$], r_last_q[$];
  int          b_cnt, late_valid;
  logic [MW-1:0][31:0] force_vec;

  // Channel monitor: records every handshake and any VALID seen after completion
  always @(posedge clk) begin
    if (rst_n) begin
      if (dut.awvalid && dut.awready) begin aw_addr_q.push_back(dut.awaddr); aw_len_q.push_back(dut.awlen); end
      if (dut.arvalid && dut.arready) begin ar_addr_q.push_back(dut.araddr); ar_len_q.push_back(dut.arlen); end
      if (dut.wvalid && dut.wready) begin w_data_q.push_back(dut.wdata); w_last_q.push_back(dut.wlast); end
      if (dut.rvalid && dut.rready) begin r_data_q.push_back(dut.rdata); r_last_q.push_back(dut.rlast); end
      if (dut.bvalid && dut.bready) b_cnt++;
      if (req_finish && (dut.awvalid || dut.wvalid || dut.bvalid || dut.arvalid || dut.rvalid)) late_valid++;
    end
  end

  typedef struct packed {
    int          abort_cycle;
    int          abort_ar;
    int          corrupt_idx;
    logic [31:0] corrupt_val;
    logic        exp_error;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] pattern(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    aw_addr_q.delete(); aw_len_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
    w_data_q.delete(); w_last_q.delete(); r_data_q.delete(); r_last_q.delete();
    b_cnt = 0;
    late_valid = 0;
  endtask

  task automatic check_reset_state(input string t);
    check($sformatf("%s/finish", t), req_finish, 1'b0);
    check($sformatf("%s/error", t), req_error, 1'b0);
    check($sformatf("%s/valids", t), {dut.awvalid, dut.wvalid, dut.bvalid, dut.arvalid, dut.rvalid}, 5'b0);
    check($sformatf("%s/readies", t), {dut.awready, dut.wready, dut.bready, dut.arready, dut.rready}, 5'b0);
    check($sformatf("%s/mem_clear", t), dut.mem_q, '0);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    string t;
    logic [MW-1:0][31:0] model;
    int guard, nbad, drop;
    t = $sformatf("v%0d", vi);
    for (int i = 0; i < MW; i++) model[i] = pattern(i);
    if (v.corrupt_idx >= 0) model[v.corrupt_idx] = v.corrupt_val;

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); check_reset_state($sformatf("%s/rst", t));
    rst_n = 1'b1; clear_mon();

    if (v.abort_cycle >= 0) begin
      repeat (v.abort_cycle) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); check_reset_state($sformatf("%s/abort", t));
      rst_n = 1'b1; clear_mon();
    end

    if (v.abort_ar >= 0) begin
      guard = 0;
      while (ar_addr_q.size() < v.abort_ar && guard < 200) begin @(negedge clk); guard++; end
      check($sformatf("%s/reach_ar", t), ar_addr_q.size(), v.abort_ar);
      @(negedge clk);
      check($sformatf("%s/in_rd_data", t), dut.rready, 1'b1);
      rst_n = 1'b0;
      @(negedge clk); check_reset_state($sformatf("%s/rd_abort", t));
      rst_n = 1'b1; clear_mon();
    end

    if (v.corrupt_idx >= 0) begin
      guard = 0;
      while (b_cnt < NB && guard < 200) begin @(negedge clk); guard++; end
      check($sformatf("%s/writes_done", t), b_cnt, NB);
      force_vec = model;
      force dut.mem_q = force_vec;
    end

    guard = 0;
    while (!req_finish && guard <= 100) begin @(negedge clk); guard++; end
    check($sformatf("%s/finish", t), req_finish, 1'b1);
    check($sformatf("%s/error", t), req_error, v.exp_error);

    check($sformatf("%s/aw_cnt", t), aw_addr_q.size(), NB);
    check($sformatf("%s/ar_cnt", t), ar_addr_q.size(), NB);
    check($sformatf("%s/b_cnt", t), b_cnt, NB);
    check($sformatf("%s/w_cnt", t), w_data_q.size(), NB * BL);
    check($sformatf("%s/r_cnt", t), r_data_q.size(), NB * BL);

    nbad = 0;
    foreach (aw_addr_q[b]) if (aw_addr_q[b] !== 32'(b * BL * 4) || aw_len_q[b] !== 8'(BL - 1)) nbad++;
    check($sformatf("%s/aw_bad", t), nbad, 0);
    nbad = 0;
    foreach (ar_addr_q[b]) if (ar_addr_q[b] !== 32'(b * BL * 4) || ar_len_q[b] !== 8'(BL - 1)) nbad++;
    check($sformatf("%s/ar_bad", t), nbad, 0);
    nbad = 0;
    foreach (w_data_q[j]) if (w_data_q[j] !== pattern(j) || w_last_q[j] !== ((j % BL) == BL - 1)) nbad++;
    check($sformatf("%s/w_bad", t), nbad, 0);
    nbad = 0;
    foreach (r_data_q[j]) if (j < MW && (r_data_q[j] !== model[j] || r_last_q[j] !== ((j % BL) == BL - 1))) nbad++;
    check($sformatf("%s/r_bad", t), nbad, 0);
    check($sformatf("%s/mem", t), dut.mem_q, model);

    drop = 0;
    repeat (50) begin @(negedge clk); if (!req_finish) drop++; end
    check($sformatf("%s/finish_held", t), drop, 0);
    check($sformatf("%s/late_valid", t), late_valid, 0);

    if (v.corrupt_idx >= 0) release dut.mem_q;
  endtask

  initial begin
    int ci;
    vecs[0] = '{-1, -1, -1, 32'h0, 1'b0};
    vecs[1] = '{-1,  3, -1, 32'h0, 1'b0};
    vecs[2] = '{-1, -1,  5, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{-1, -1, 15, 32'h25A5_000F, 1'b1};
    vecs[4] = '{-1, -1,  0, 32'hA5A5_0001, 1'b1};
    vecs[5] = '{int'($urandom_range(1, 50)), -1, -1, 32'h0, 1'b0};
    vecs[6] = '{int'($urandom_range(1, 50)), -1, -1, 32'h0, 1'b0};
    ci = int'($urandom_range(0, MW - 1));
    vecs[7] = '{int'($urandom_range(1, 50)), -1, ci, pattern(ci) ^ ($urandom | 32'h1), 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_top.md
AXI_TOP -- requirements
Module: axi_top

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI data width in bits (fixed at 32).
REQ-002 Parameter MEM_WORDS, default 16, slave memory depth in words.
REQ-003 Parameter BURST_LEN, default 4, beats per burst (AxLEN = BURST_LEN-1).
REQ-004 Parameter NUM_BURSTS, default 4, bursts per phase; NUM_BURSTS*BURST_LEN SHALL equal MEM_WORDS.
REQ-005 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 Port req_finish, output, 1, high when the full write/read-back sequence has completed.
REQ-008 Port req_error, output, 1, high when any read-back beat mismatched or any response was not OKAY.

Function
REQ-009 axi_top SHALL contain one AXI4 master and one AXI4 memory slave connected by internal AW, W, B, AR and R channels, with 32-bit address, 32-bit data and no ID signals.
REQ-010 A transfer on any channel SHALL occur only on a rising edge where VALID and READY are both high.
- VALID, once high, SHALL hold with a stable payload until the handshake.
- VALID SHALL NOT depend combinationally on READY.
REQ-011 Master FSM states SHALL be IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA and DONE.
REQ-012 Master FSM transitions:
- IDLE->WR_ADDR one cycle after reset release.
- WR_ADDR->WR_DATA on AW handshake.
- WR_DATA->WR_RESP on the WLAST handshake.
- WR_RESP->WR_ADDR (next burst) or RD_ADDR (after burst NUM_BURSTS-1) on B handshake.
- RD_ADDR->RD_DATA on AR handshake.
- RD_DATA->RD_ADDR (next burst) or DONE (after burst NUM_BURSTS-1) on the RLAST handshake.
- DONE is terminal until reset.
REQ-013 Burst b address SHALL be b*BURST_LEN*4 (0x00, 0x10, 0x20, 0x30), with AxLEN=3, AxSIZE=2 and AxBURST=INCR.
REQ-014 Write beat k of burst b SHALL carry data 0xA5A5_0000 | (b*BURST_LEN+k) and WSTRB=4'hF, with WLAST high on k=BURST_LEN-1 only.
REQ-015 Slave handling of AW and AR:
- Accept one burst at a time.
- AWREADY and ARREADY SHALL each be a one-cycle pulse when the slave is idle.
- Writes have priority if both are pending.
REQ-016 Slave write data path:
- Hold WREADY high during the write data phase.
- Store each beat at word index addr[5:2]+beat, honouring WSTRB per byte.
- Assert BVALID with BRESP=OKAY the cycle after the WLAST handshake.
REQ-017 Slave read data path:
- Drive RVALID from the cycle after the AR handshake, one beat per cycle while RREADY is high.
- RDATA is the word at index addr[5:2]+beat, RRESP=OKAY, RLAST on the final beat.
REQ-018 Master SHALL hold BREADY high in WR_RESP and RREADY high in RD_DATA.
REQ-019 Master SHALL compare each RDATA beat with the REQ-014 value for that address.
- Any mismatch, or any BRESP/RRESP not OKAY, SHALL set a sticky error flag driving req_error.
REQ-020 req_finish SHALL be registered and go high on the first cycle in DONE, then stay high until reset; req_error is valid whenever req_finish is high.
REQ-021 Full sequence latency from reset release to req_finish SHALL be at most 100 clk cycles.
REQ-022 Addresses beyond MEM_WORDS SHALL wrap modulo MEM_WORDS; the defaults never reach this case.

Reset
REQ-023 While rst_n is low at a rising edge, the following SHALL all be cleared:
- FSM state to IDLE and burst/beat counters to 0.
- All VALID and READY outputs to 0.
- req_finish and req_error to 0.
- All memory words to 0.
REQ-024 Reset asserted mid-sequence (any state) SHALL abort outstanding bursts without completing them; after release the sequence SHALL restart from burst 0 write.

Verification
REQ-025 Hold rst_n low 1 cycle then release -> req_finish rises within 100 cycles, and req_error=0.
REQ-026 After req_finish -> memory word i = 0xA5A5_0000+i for i=0..15; 4 AW, 4 B, 4 AR handshakes and 16 W and 16 R beats have occurred.
REQ-027 Observe the AW/AR channels -> addresses 0x00, 0x10, 0x20, 0x30 in order, AxLEN=3, and WLAST/RLAST only on beat 3.
REQ-028 Assert rst_n low during RD_DATA of burst 2 -> req_finish=0 next cycle and all VALIDs low; after release the sequence restarts at AWADDR 0x00 and finishes with req_error=0.
REQ-029 Force one slave memory word to a corrupt value after its write completes -> req_finish=1 with req_error=1.
REQ-030 Hold clk running after DONE for 50 cycles -> req_finish stays 1 and no further VALID asserts.
